branch_target_table: RTL

Parametrised branch target table for the fetch stage. Maps a branch PC (key) to a predicted target (val). Each entry carries a separate valid bit and an N-bit saturating direction counter. Successor to the fixed 32-entry, 2-bit table, adding:
- configurable depth and counter width
- free-slot-first replacement
- single-cycle flush
- optional no-allocate-on-not-taken mode
- occupancy count

Sits between the PC generator (lookup) and the execute stage (branch resolution updates).

---
 rtl/branch_target_table_pkg.sv | 30 +++
 rtl/branch_target_table_if.sv | 32 +++
 rtl/branch_target_table_lowest_set_encoder.sv | 22 ++
 rtl/branch_target_table.sv | 100 ++++++++++
 4 files changed

// File: rtl/branch_target_table_pkg.sv
// Shared types and saturating direction-counter helpers for the branch target table.
package branch_target_table_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_HIT,
        UPD_FILL,
        UPD_EVICT
    } update_e;

    // Counters are passed zero-extended to 32 bits; width must be 1..32.
    function automatic logic [31:0] ctr_max(input int unsigned width);
        return 32'hFFFF_FFFF >> (32 - width);
    endfunction

    function automatic logic [31:0] ctr_inc(input logic [31:0] ctr, input int unsigned width);
        return (ctr == ctr_max(width)) ? ctr : ctr + 32'd1;
    endfunction

    function automatic logic [31:0] ctr_dec(input logic [31:0] ctr);
        return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

    function automatic logic predict_taken(input logic [31:0] ctr, input int unsigned width);
        return ctr[width-1];
    endfunction

endpackage

// File: rtl/branch_target_table_if.sv
// Lookup, update and status signals between fetch/execute and the branch target table.
interface branch_target_table_if
    import branch_target_table_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned ENTRIES    = 32,
    parameter int unsigned CTR_WIDTH  = 2
);
    localparam int unsigned COUNT_WIDTH = $clog2(ENTRIES) + 1;

    logic                   flush;
    logic                   write;
    logic [ADDR_WIDTH-1:0]  write_key;
    logic [ADDR_WIDTH-1:0]  write_val;
    logic                   write_taken;
    logic [ADDR_WIDTH-1:0]  read_key;
    logic                   read_hit;
    logic                   read_valid;
    logic [ADDR_WIDTH-1:0]  read_val;
    logic [CTR_WIDTH-1:0]   read_ctr;
    logic [COUNT_WIDTH-1:0] count;

    modport master (
        output flush, write, write_key, write_val, write_taken, read_key,
        input  read_hit, read_valid, read_val, read_ctr, count
    );

    modport slave (
        input  flush, write, write_key, write_val, write_taken, read_key,
        output read_hit, read_valid, read_val, read_ctr, count
    );
endinterface

// File: rtl/branch_target_table_lowest_set_encoder.sv
// Priority encoder: index of the lowest set bit of a vector, plus an any-set flag.
module lowest_set_encoder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         bits,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int unsigned IW = $clog2(N);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = N; i > 0; i--) begin
            if (bits[i-1]) begin
                idx = IW'(i - 1);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/branch_target_table.sv
// Fully associative branch target table: PC -> target with per-entry saturating direction counter.
module branch_target_table
    import branch_target_table_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
    parameter int unsigned ENTRIES         = 32,
    parameter int unsigned CTR_WIDTH       = 2,
    parameter bit          ALLOC_NOT_TAKEN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_target_table_if.slave bus
);
    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned CW = $clog2(ENTRIES) + 1;

    logic [ADDR_WIDTH-1:0] keys [ENTRIES];
    logic [ADDR_WIDTH-1:0] vals [ENTRIES];
    logic [CTR_WIDTH-1:0]  ctrs [ENTRIES];
    logic [ENTRIES-1:0]    valid;
    logic [IW-1:0]         current;
    logic [CW-1:0]         count;

    logic [ENTRIES-1:0] r_match, w_match, free;
    logic [IW-1:0]      r_idx, w_idx, f_idx, victim;
    logic               r_any, w_any, f_any;
    update_e            action;

    always_comb begin
        r_match = '0;
        w_match = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_match[i] = valid[i] && (keys[i] == bus.read_key);
            w_match[i] = valid[i] && (keys[i] == bus.write_key);
        end
        free = ~valid;
    end

    lowest_set_encoder #(.N(ENTRIES)) u_read_enc  (.bits(r_match), .idx(r_idx), .any(r_any));
    lowest_set_encoder #(.N(ENTRIES)) u_write_enc (.bits(w_match), .idx(w_idx), .any(w_any));
    lowest_set_encoder #(.N(ENTRIES)) u_free_enc  (.bits(free),    .idx(f_idx), .any(f_any));

    always_comb begin
        action = UPD_NONE;
        if (bus.write) begin
            if (w_any)
                action = UPD_HIT;
            else if (bus.write_taken || ALLOC_NOT_TAKEN)
                action = f_any ? UPD_FILL : UPD_EVICT;
        end
        victim = (action == UPD_FILL) ? f_idx : current;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= '0;
            current <= '0;
            count   <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                keys[i] <= '0;
                vals[i] <= '0;
                ctrs[i] <= '0;
            end
        end else if (bus.flush) begin
            valid   <= '0;
            current <= '0;
            count   <= '0;
        end else begin
            case (action)
                UPD_HIT: begin
                    if (bus.write_taken) begin
                        ctrs[w_idx] <= CTR_WIDTH'(ctr_inc(32'(ctrs[w_idx]), CTR_WIDTH));
                        vals[w_idx] <= bus.write_val;
                    end else begin
                        ctrs[w_idx] <= CTR_WIDTH'(ctr_dec(32'(ctrs[w_idx])));
                    end
                end
                UPD_FILL, UPD_EVICT: begin
                    keys[victim]  <= bus.write_key;
                    vals[victim]  <= bus.write_val;
                    valid[victim] <= 1'b1;
                    ctrs[victim]  <= bus.write_taken ? CTR_WIDTH'(ctr_max(CTR_WIDTH)) : '0;
                    if (action == UPD_FILL)
                        count <= count + CW'(1);
                    else
                        current <= current + IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.read_hit   = r_any;
        bus.read_val   = r_any ? vals[r_idx] : '0;
        bus.read_ctr   = r_any ? ctrs[r_idx] : '0;
        bus.read_valid = r_any && predict_taken(32'(ctrs[r_idx]), CTR_WIDTH);
        bus.count      = count;
    end
endmodule
